// File: rtl/mem_pkg.sv
// Shared data-memory definitions: bus widths, access-size encoding and the
// byte reader state encoding.
package mem_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 19;

   typedef enum logic {
      SIZE_BYTE = 1'b0,
      SIZE_HALF = 1'b1
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/mem_byte_reader.sv
// Byte-stream read initiator: walks a byte region of data memory and emits
// each byte on a valid/ready stream. Never writes memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, memory lanes parked at address 0
// ST_FETCH | mem_a = current byte address, read data captured at edge
// ST_HOLD  | byte presented on out_data/out_valid until consumer takes it
// ST_DONE  | one-cycle done pulse, then back to idle
module mem_byte_reader
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_we,
   output logic              mem_cant_byte,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   rd_state_e         state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W-1:0] remain, remain_nxt;
   logic [7:0]        data_nxt;

   // Only the low byte of the read bus carries data in byte mode.
   logic [DATA_W-9:0] rd_hi_unused;
   assign rd_hi_unused = mem_rd[DATA_W-1:8];

   assign mem_we        = 1'b0;
   assign mem_cant_byte = SIZE_BYTE;

   // State, address/remaining counters and output byte register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         addr     <= '0;
         remain   <= '0;
         out_data <= 8'h00;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         remain   <= remain_nxt;
         out_data <= data_nxt;
      end
   end

   // Next-state, counter updates and state-decoded outputs.
   always_comb begin
      state_nxt  = state;
      addr_nxt   = addr;
      remain_nxt = remain;
      data_nxt   = out_data;
      mem_a      = '0;
      busy       = 1'b1;
      done       = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               addr_nxt   = base_addr;
               remain_nxt = length;
               state_nxt  = (length == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            mem_a     = addr;
            data_nxt  = mem_rd[7:0];
            state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            mem_a     = addr;
            out_valid = 1'b1;
            if (out_ready) begin
               if (remain == ADDR_W'(1)) begin
                  state_nxt = ST_DONE;
               end else begin
                  // Address wraps naturally at 2^ADDR_W.
                  addr_nxt   = addr + ADDR_W'(1);
                  remain_nxt = remain - ADDR_W'(1);
                  state_nxt  = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_byte_reader.sv
// Scoreboard bench for mem_byte_reader: expected bytes/addresses are queued
// when a transfer is launched and popped on each stream handshake.
module tb_mem_byte_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [18:0] base_addr;
   logic [18:0] length;
   logic        busy;
   logic        done;
   logic [18:0] mem_a;
   logic        mem_we;
   logic        mem_cant_byte;
   logic [18:0] mem_rd;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   mem_byte_reader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .length        (length),
      .busy          (busy),
      .done          (done),
      .mem_a         (mem_a),
      .mem_we        (mem_we),
      .mem_cant_byte (mem_cant_byte),
      .mem_rd        (mem_rd),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic [18:0] a;
      int          off;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          hs_cnt = 0;
   bit          done_pending = 1'b0;
   int          done_off = -1;
   bit          stall_prev = 1'b0;
   logic [7:0]  prev_data;
   logic [18:0] prev_a;
   logic [7:0]  last_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: halfword index 4 holds 16'hBEEF (little-endian bytes 8,9),
   // everywhere else a byte reads back as its own address low byte.
   function automatic logic [7:0] model_byte(input logic [18:0] a);
      logic [15:0] hw;
      hw = 16'hBEEF;
      if (a[18:1] == 18'h4) return a[0] ? hw[15:8] : hw[7:0];
      return a[7:0];
   endfunction

   // Upper read-data bits carry junk that the reader must ignore.
   assign mem_rd = {mem_a[18:8] ^ 11'h5A5, model_byte(mem_a)};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: handshakes against the scoreboard, hold stability, done pulses.
   always @(negedge clk) begin
      if (!reset) begin
         stall_prev = 1'b0;
      end else begin
         chk("mem_we", mem_we, 0);
         chk("mem_cant_byte", mem_cant_byte, 0);
         if (!busy) begin
            chk("idle_mem_a", mem_a, 0);
            chk("idle_valid", out_valid, 0);
         end
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_addr", mem_a, prev_a);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("extra_byte", out_data, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("byte", out_data, e.data);
               chk("addr", mem_a, e.a);
               if (e.off >= 0) chk("hs_time", cyc - start_cyc, e.off);
            end
            hs_cnt++;
            last_data = out_data;
         end
         if (done) begin
            if (!done_pending) begin
               chk("spurious_done", 1, 0);
            end else begin
               if (done_off >= 0) chk("done_time", cyc - start_cyc, done_off);
               chk("done_q_empty", q.size(), 0);
               done_pending = 1'b0;
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_a     = mem_a;
      end
   end

   // Launch one transfer and steer out_ready / start glitch / reset abort.
   task automatic run_xfer(input logic [18:0] b, input logic [18:0] n,
                           input int stall_idx, input int stall_len,
                           input int glitch_off, input int rst_idx);
      bit timed;
      bit aborted;
      int stall;
      logic [18:0] ad;
      timed   = (stall_idx < 0);
      aborted = 1'b0;
      stall   = 0;
      @(posedge clk); #1;
      base_addr = b;
      length    = n;
      start     = 1'b1;
      out_ready = 1'b1;
      start_cyc = cyc + 1;
      hs_cnt    = 0;
      for (int k = 0; k < int'(n); k++) begin
         exp_t e;
         ad     = b + 19'(k);
         e.data = model_byte(ad);
         e.a    = ad;
         e.off  = timed ? 2 * k + 1 : -1;
         q.push_back(e);
      end
      done_pending = 1'b1;
      done_off     = timed ? 2 * int'(n) : -1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = 19'h33333;
      length    = 19'h00007;
      for (int i = 0; i < 400 && done_pending; i++) begin
         start = (i == glitch_off);
         if (i == glitch_off) base_addr = 19'h00055;
         if (rst_idx >= 0 && hs_cnt == rst_idx && stall >= 2) begin
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            q.delete();
            done_pending = 1'b0;
            aborted = 1'b1;
            chk("rst_busy", busy, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_mem_a", mem_a, 0);
            break;
         end
         if (hs_cnt == stall_idx && stall < stall_len) begin
            out_ready = 1'b0;
            if (out_valid) begin
               stall++;
               ad = b + 19'(stall_idx);
               chk("bp_data", out_data, model_byte(ad));
               chk("bp_addr", mem_a, ad);
            end
         end else begin
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      if (done_pending) begin
         chk("timeout", 0, 1);
         done_pending = 1'b0;
         q.delete();
      end
      if (!aborted) begin
         chk("byte_count", hs_cnt, n);
         chk("idle_after_done", busy, 0);
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy0", busy, 0);
      chk("rst_done0", done, 0);
      chk("rst_valid0", out_valid, 0);
      chk("rst_data0", out_data, 0);
      chk("rst_mem_a0", mem_a, 0);
      chk("rst_we0", mem_we, 0);
      chk("rst_size0", mem_cant_byte, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      run_xfer(19'h00010, 19'd4, -1, 0, -1, -1);
      run_xfer(19'h00010, 19'd4, 1, 5, -1, -1);
      run_xfer(19'h00009, 19'd1, -1, 0, -1, -1);
      chk("odd_byte", last_data, 8'hBE);
      run_xfer(19'h7FFFE, 19'd3, -1, 0, -1, -1);
      run_xfer(19'h00040, 19'd0, -1, 0, -1, -1);
      chk("zero_len_bytes", hs_cnt, 0);
      run_xfer(19'h00010, 19'd4, -1, 0, 3, -1);
      run_xfer(19'h00020, 19'd4, 1, 20, -1, 1);
      run_xfer(19'h00030, 19'd2, -1, 0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
